bird_obstacle: RTL and testbench
================================

// Module: bird_obstacle
// PURPOSE
//  Flying-bird obstacle for the dino runner. Spawns off the right screen edge at one of three
//  heights chosen from rand_i, then scrolls left a fixed step per video frame. Its 2-frame
//  wing-flap sprite is rendered combinationally for the current pixel, for the display mixer
//  and for collision logic. Sibling of the cactus obstacle, with the same spawn/scroll interface.
// PARAMETERS
//  BirdW      32   sprite width, px
//  BirdH      24   sprite height, px
//  Speed      4    leftward step per frame, px
//  FlapFrames 8    frames per wing-flap phase
//  GroundY    400  ground line row; low lane top = GroundY-BirdH
//  LaneStep   40   vertical gap between lanes, px
//  ScreenWidth/ScreenHeight come from dinorun_pkg (640/480).
// PORTS
//  clk_i        in   1   system clock
//  rst_ni       in   1   reset; one clock; asynchronous, active-low
//  next_frame_i in   1   one-cycle strobe at end of each frame; all state advances only here
//  spawn_i      in   1   spawn request, sampled only on next_frame_i
//  rand_i       in   8   random byte; [1:0] selects lane at spawn
//  pixel_x_i    in   10  current pixel column, 0..ScreenWidth-1
//  pixel_y_i    in   10  current pixel row, 0..ScreenHeight-1
//  pixel_o      out  1   1 = bird covers (pixel_x_i,pixel_y_i)
//  active_o     out  1   1 = bird alive (on or entering screen)
// BEHAVIOUR
//  - State: FSM IDLE/ACTIVE; x_q signed 11b (left edge); y_q 10b (top edge); flap_q 1b;
//    flap_cnt_q 3b.
//  - Reset (async, rst_ni=0): IDLE, x_q=ScreenWidth, y_q=GroundY-BirdH, flap_q=0, flap_cnt_q=0.
//    pixel_o=0, active_o=0 while in reset.
//  - Registers hold whenever next_frame_i=0.
//  - IDLE & next_frame_i & spawn_i -> ACTIVE, x_q=ScreenWidth, flap_q=0, flap_cnt_q=0.
//    y_q from rand_i[1:0]: 0 -> GroundY-BirdH (low), 1 -> GroundY-BirdH-LaneStep (mid),
//    2 -> GroundY-BirdH-2*LaneStep (high), 3 -> mid.
//  - IDLE & next_frame_i & !spawn_i -> stay IDLE.
//  - ACTIVE & next_frame_i: x_q <= x_q-Speed. If x_q-Speed <= -BirdW, go to IDLE
//    (fully off left edge). spawn_i is ignored while ACTIVE; there is never a second bird.
//  - Flap: in ACTIVE each next_frame_i increments flap_cnt_q. On reaching FlapFrames-1, it wraps
//    to 0 and toggles flap_q.
//  - active_o = (state==ACTIVE).
//  - pixel_o is combinational, zero latency:
//    active & dx=pixel_x_i-x_q in [0,BirdW) & dy=pixel_y_i-y_q in [0,BirdH) & sprite[flap_q][dy][dx].
//    Do the subtraction in signed 12b so negative x_q clips correctly at the left edge.
//  - x_q >= ScreenWidth: nothing visible; pixel_x_i never reaches x_q.
//  - Sprite ROM: two BirdW x BirdH bitmaps, 0 = wings up, 1 = wings down.
//    Both set body rows 10..15, cols 8..27 (includes bit [12][16]); beak cols 0..7, rows 10..12.
//    Frame 0 sets rows 0..9 cols 14..21 (wing up), rows 16..23 clear.
//    Frame 1 sets rows 16..23 cols 14..21 (wing down), rows 0..9 clear.
//  - next_frame_i while pixel inputs are changing: position updates after that edge;
//    pixel_o follows next cycle's state.
//  - Reset mid-flight: immediately IDLE, bird disappears.
// TESTING
//  1. Reset, scan full 640x480 -> pixel_o=0 everywhere, active_o=0.
//  2. rand_i=0, spawn_i=1, 1 frame strobe -> active_o=1, x_q=640, no pixels.
//     10 more strobes -> x_q=600; pixel(616,388)=1, pixel(599,388)=0, pixel(632,388)=0.
//  3. rand_i=2 spawn, 10 frames -> pixel(616,308)=1, pixel(616,388)=0; rand_i=3 -> pixel(616,348)=1.
//  4. Hold spawn_i=1 with varying rand_i -> lane never changes mid-flight.
//     After spawn + 168 strobes -> active_o=0; next strobe respawns at x_q=640.
//  5. Flap: frames 0..7 after spawn, bit rows 0..9 visible; frames 8..15 rows 16..23 visible.
//  6. x_q=-20 (after 165 moves) -> pixel(0..11, body row) follow sprite cols 20..31,
//     with no wrap to the right edge. Assert rst_ni=0 mid-flight -> pixel_o=0 immediately.

Source files
------------

// File: rtl/bird_obstacle.sv
// bird_obstacle: flying-bird obstacle that spawns off the right edge in one of three lanes,
// scrolls left once per frame and renders a two-phase wing-flap sprite for the current pixel.
module bird_obstacle #(
    parameter int BirdW        = 32,
    parameter int BirdH        = 24,
    parameter int Speed        = 4,
    parameter int FlapFrames   = 8,
    parameter int GroundY      = 400,
    parameter int LaneStep     = 40,
    parameter int ScreenWidth  = 640,
    parameter int ScreenHeight = 480
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       next_frame_i,
    input  logic       spawn_i,
    input  logic [7:0] rand_i,
    input  logic [9:0] pixel_x_i,
    input  logic [9:0] pixel_y_i,
    output logic       pixel_o,
    output logic       active_o
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic signed [10:0] XStart = 11'(ScreenWidth);
    localparam logic signed [10:0] XStep  = 11'(Speed);
    localparam logic signed [10:0] XGone  = 11'(-BirdW);
    localparam logic [9:0]         YLow   = 10'(GroundY - BirdH);
    localparam logic [9:0]         YMid   = 10'(GroundY - BirdH - LaneStep);
    localparam logic [9:0]         YHigh  = 10'(GroundY - BirdH - 2 * LaneStep);
    localparam logic [2:0]         FlapLast = 3'(FlapFrames - 1);

    state_t            state_q, state_d;
    logic signed [10:0] x_q, x_d, x_next;
    logic [9:0]        y_q, y_d, lane_y;
    logic              flap_q, flap_d, flap_wrap;
    logic [2:0]        flap_cnt_q, flap_cnt_d;
    logic signed [11:0] dx, dy;
    logic [4:0]        col, row;
    logic              in_box, body, beak, wing;
    logic              unused_rand;

    assign unused_rand = ^rand_i[7:2];
    assign x_next      = x_q - XStep;
    assign flap_wrap   = flap_cnt_q == FlapLast;
    assign lane_y      = rand_i[1:0] == 2'd0 ? YLow : rand_i[1:0] == 2'd2 ? YHigh : YMid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            x_q        <= XStart;
            y_q        <= YLow;
            flap_q     <= 1'b0;
            flap_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            flap_q     <= flap_d;
            flap_cnt_q <= flap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        flap_d     = flap_q;
        flap_cnt_d = flap_cnt_q;
        if (next_frame_i && state_q == IDLE && spawn_i) begin
            state_d    = ACTIVE;
            x_d        = XStart;
            y_d        = lane_y;
            flap_d     = 1'b0;
            flap_cnt_d = 3'd0;
        end else if (next_frame_i && state_q == ACTIVE) begin
            x_d        = x_next;
            state_d    = x_next <= XGone ? IDLE : ACTIVE;
            flap_cnt_d = flap_wrap ? 3'd0 : flap_cnt_q + 3'd1;
            flap_d     = flap_q ^ flap_wrap;
        end
    end

    // signed 12b offsets so a partly off-screen bird (negative x_q) clips instead of wrapping
    assign dx     = $signed({2'b00, pixel_x_i}) - $signed({x_q[10], x_q});
    assign dy     = $signed({2'b00, pixel_y_i}) - $signed({2'b00, y_q});
    assign in_box = !dx[11] && dx[10:0] < 11'(BirdW) && !dy[11] && dy[10:0] < 11'(BirdH);
    assign col    = dx[4:0];
    assign row    = dy[4:0];
    assign body   = row >= 5'd10 && row <= 5'd15 && col >= 5'd8 && col <= 5'd27;
    assign beak   = row >= 5'd10 && row <= 5'd12 && col <= 5'd7;
    assign wing   = col >= 5'd14 && col <= 5'd21 && (flap_q ? row >= 5'd16 && row <= 5'd23 : row <= 5'd9);

    assign active_o = state_q == ACTIVE;
    assign pixel_o  = active_o && in_box && (body || beak || wing);
endmodule

// File: tb/tb_bird_obstacle.sv
// tb_bird_obstacle: directed and randomized checks of bird_obstacle against a
// frame-count based reference model of the bird's flight.
module tb_bird_obstacle;
    logic       clk = 0, rst_n = 0, next_frame = 0, spawn = 0;
    logic [7:0] rand_b = 0;
    logic [9:0] pixel_x = 0, pixel_y = 0;
    logic       pixel, active;
    int         n_chk = 0, n_fail = 0;

    bird_obstacle dut (
        .clk_i(clk), .rst_ni(rst_n), .next_frame_i(next_frame), .spawn_i(spawn),
        .rand_i(rand_b), .pixel_x_i(pixel_x), .pixel_y_i(pixel_y),
        .pixel_o(pixel), .active_o(active)
    );

    always #5 clk = ~clk;

    // reference: bird position derived from frames elapsed since spawn
    bit spr[2][24][32];
    bit m_alive = 0;
    int m_n = 0, m_y = 376;

    initial
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 24; r++)
                for (int c = 0; c < 32; c++)
                    spr[f][r][c] = (r >= 10 && r <= 15 && c >= 8 && c <= 27) ||
                                   (r >= 10 && r <= 12 && c < 8) ||
                                   (c >= 14 && c <= 21 && (f == 1 ? r >= 16 : r <= 9));

    function automatic int bird_x();
        return 640 - 4 * m_n;
    endfunction

    function automatic bit model_pix(int px, int py);
        int dx, dy;
        dx = px - bird_x();
        dy = py - m_y;
        if (!m_alive || dx < 0 || dx >= 32 || dy < 0 || dy >= 24) return 0;
        return spr[(m_n / 8) % 2][dy][dx];
    endfunction

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic strobe();
        @(negedge clk);
        next_frame = 1;
        @(posedge clk);
        if (!m_alive) begin
            if (spawn) begin
                m_alive = 1;
                m_n = 0;
                m_y = rand_b[1:0] == 0 ? 376 : rand_b[1:0] == 2 ? 296 : 336;
            end
        end else begin
            m_n++;
            if (bird_x() <= -32) m_alive = 0;
        end
        @(negedge clk);
        next_frame = 0;
        #1;
    endtask

    task automatic pix(string tag, int x, int y);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        #1;
        check(tag, int'(pixel), int'(model_pix(x, y)));
    endtask

    task automatic do_reset();
        rst_n = 0;
        m_alive = 0;
        #1;
        check("rst_active", int'(active), 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic int clip(int v, int hi);
        return v < 0 ? 0 : v > hi ? hi : v;
    endfunction

    initial begin
        int hits;
        // reset: whole screen dark
        do_reset();
        rst_n = 0;
        hits = 0;
        for (int y = 0; y < 480; y++)
            for (int x = 0; x < 640; x++) begin
                pixel_x = 10'(x);
                pixel_y = 10'(y);
                #1;
                hits += int'(pixel);
            end
        check("rst_scan_pixels", hits, 0);
        rst_n = 1;

        // spawn low lane, first frame off-screen
        spawn = 1;
        rand_b = 8'h00;
        strobe();
        spawn = 0;
        check("spawn_active", int'(active), 1);
        pix("spawn_nopix", 639, 388);
        repeat (10) strobe();
        pix("low_body", 616, 388);
        check("low_body_const", int'(pixel), 1);
        pix("low_left_out", 599, 388);
        pix("low_right_out", 632, 388);
        // flap phases across frames 0..15 (x moves, sprite offsets from model)
        do_reset();
        spawn = 1;
        rand_b = 8'h02;
        strobe();
        spawn = 0;
        for (int k = 1; k < 16; k++) begin
            strobe();
            pix("flap_up", bird_x() + 17, m_y + 4);
            pix("flap_down", bird_x() + 17, m_y + 20);
        end
        // high / mid lanes
        do_reset();
        spawn = 1;
        rand_b = 8'h02;
        strobe();
        spawn = 0;
        repeat (10) strobe();
        pix("high_body", 616, 308);
        pix("high_not_low", 616, 388);
        do_reset();
        spawn = 1;
        rand_b = 8'h03;
        strobe();
        spawn = 0;
        repeat (10) strobe();
        pix("mid_body", 616, 348);
        check("mid_body_const", int'(pixel), 1);

        // spawn held with changing rand: lane fixed, leaves after 168 moves, respawns
        do_reset();
        spawn = 1;
        rand_b = 8'h01;
        strobe();
        for (int k = 0; k < 168; k++) begin
            rand_b = 8'($urandom);
            strobe();
            if (k % 20 == 0) pix("held_lane", clip(bird_x() + 16, 639), 348);
        end
        check("exit_active", int'(active), 0);
        rand_b = 8'h00;
        strobe();
        check("respawn_active", int'(active), 1);
        pix("respawn_hidden", 639, 388);
        strobe();
        pix("respawn_x636", 639, 386);

        // left-edge clipping at x=-20, then async reset mid-flight
        do_reset();
        spawn = 1;
        rand_b = 8'h00;
        strobe();
        spawn = 0;
        repeat (165) strobe();
        for (int x = 0; x < 14; x++) pix("left_clip", x, 388);
        pix("no_wrap_right", 639, 388);
        pix("no_wrap_620", 620, 388);
        pixel_x = 10'd5;
        pixel_y = 10'd388;
        rst_n = 0;
        m_alive = 0;
        #1;
        check("rst_mid_pixel", int'(pixel), 0);
        check("rst_mid_active", int'(active), 0);
        @(negedge clk);
        rst_n = 1;

        // randomized flight
        for (int k = 0; k < 800; k++) begin
            spawn = ($urandom_range(0, 3) == 0);
            rand_b = 8'($urandom);
            strobe();
            check("rnd_active", int'(active), int'(m_alive));
            for (int j = 0; j < 4; j++) begin
                pix("rnd_near", clip(bird_x() + $urandom_range(0, 40) - 4, 639),
                    clip(m_y + $urandom_range(0, 30) - 3, 479));
            end
            pix("rnd_any", $urandom_range(0, 639), $urandom_range(0, 479));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
